crc3_checker: RTL and testbench

//   Receive-side stage directly downstream of the CRC-3 generator. Accepts one 8-bit codeword
//   {msg[4:0], crc[2:0]}, recomputes the CRC serially over 8 cycles with the generator's exact

---
 rtl/crc3_pkg.sv | 14 +
 rtl/crc3_lfsr.sv | 35 +++
 rtl/crc3_checker.sv | 114 +++++++++++
 tb/tb_crc3_checker.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/crc3_pkg.sv
// Shared CRC-3 definitions used by both the generator and the checker.
package crc3_pkg;
    localparam int CRC3_W   = 3;
    localparam int MSG_W    = 5;
    localparam int CW_W     = 8;
    localparam int PAD_BITS = 3;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // One serial step; the generator uses the same rule, so both ends agree bit-for-bit.
    function automatic logic [CRC3_W-1:0] crc3_step(input logic [CRC3_W-1:0] c, input logic b);
        return {b ^ c[2] ^ c[0], c[2], c[1]};
    endfunction
endpackage

// File: rtl/crc3_lfsr.sv
// 3-bit serial CRC register with synchronous clear and step enable.
module crc3_lfsr
    import crc3_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              step,
    input  logic              bit_in,
    output logic [CRC3_W-1:0] crc,
    output logic [CRC3_W-1:0] crc_next
);
    logic [CRC3_W-1:0] crc_q;
    logic [CRC3_W-1:0] crc_d;

    assign crc_next = crc3_step(crc_q, bit_in);
    assign crc      = crc_q;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = '0;
        end else if (step) begin
            crc_d = crc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end
endmodule

// File: rtl/crc3_checker.sv
// Receive-side CRC-3 checker: serially recomputes the CRC of a latched codeword and
// presents message, pass/fail and syndrome on a valid/ready port; counts failures.
module crc3_checker
    import crc3_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 cw_valid,
    input  logic [7:0]           cw_data,
    output logic                 cw_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4:0]           msg_data,
    output logic                 crc_ok,
    output logic [2:0]           syndrome,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_count
);
    state_t                state_q, state_d;
    logic [CW_W-1:0]       cw_q, cw_d;
    logic [2:0]            idx_q, idx_d;
    logic [ERR_CNT_W-1:0]  err_q, err_d;

    logic                  accept;
    logic                  step_en;
    logic                  last_step;
    logic                  shift_bit;
    logic [CW_W-1:0]       padded;
    logic [CRC3_W-1:0]     crc_cur;
    logic [CRC3_W-1:0]     crc_next;
    logic [CRC3_W-1:0]     syn_next;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
        return (c == '1) ? c : c + ERR_CNT_W'(1);
    endfunction

    assign accept    = cw_valid && (state_q == IDLE);
    assign step_en   = en && (state_q == SHIFT);
    assign last_step = step_en && (idx_q == 3'd7);

    // Message bits go out MSB first, followed by PAD_BITS zeros to flush the register.
    assign padded    = {cw_q[CW_W-1 -: MSG_W], {PAD_BITS{1'b0}}};
    assign shift_bit = padded[3'd7 - idx_q];
    assign syn_next  = cw_q[CRC3_W-1:0] ^ crc_next;

    crc3_lfsr u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .step     (step_en),
        .bit_in   (shift_bit),
        .crc      (crc_cur),
        .crc_next (crc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cw_valid)              state_d = SHIFT;
            SHIFT:   if (last_step)             state_d = DONE;
            DONE:    if (out_ready)             state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    always_comb begin
        cw_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        msg_data  = cw_q[CW_W-1 -: MSG_W];
        syndrome  = out_valid ? (cw_q[CRC3_W-1:0] ^ crc_cur) : '0;
        crc_ok    = out_valid && (syndrome == '0);
        err_count = err_q;
    end

    always_comb begin
        cw_d  = accept ? cw_data : cw_q;
        idx_d = idx_q;
        if (accept) begin
            idx_d = '0;
        end else if (step_en) begin
            idx_d = idx_q + 3'd1;
        end
        // A clear request wins over an increment on the same edge.
        err_d = err_q;
        if (err_clr) begin
            err_d = '0;
        end else if (last_step && (syn_next != '0)) begin
            err_d = sat_inc(err_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cw_q  <= '0;
            idx_q <= '0;
            err_q <= '0;
        end else begin
            cw_q  <= cw_d;
            idx_q <= idx_d;
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_crc3_checker.sv
// Randomized bench for crc3_checker with a transaction-level reference model; runs a
// default-width and a 2-bit-counter instance side by side on the same stimulus.
module tb_crc3_checker;
    logic       clk = 1'b0;
    logic       reset, en, cw_valid, out_ready, err_clr;
    logic [7:0] cw_data;

    logic       cw_ready, out_valid, crc_ok;
    logic [4:0] msg_data;
    logic [2:0] syndrome;
    logic [7:0] err_count;

    logic       cw_ready_n, out_valid_n, crc_ok_n;
    logic [4:0] msg_data_n;
    logic [2:0] syndrome_n;
    logic [1:0] err_count_n;

    int n_checks = 0;
    int n_fail   = 0;

    bit         mon_en = 1'b0;
    bit         exp_rdy, exp_ov, exp_bad;
    logic [4:0] exp_msg;
    logic [2:0] exp_syn;
    int         exp_cnt8, exp_cnt2;

    always #5 clk = ~clk;

    crc3_checker #(.ERR_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .cw_valid(cw_valid), .cw_data(cw_data),
        .cw_ready(cw_ready), .out_valid(out_valid), .out_ready(out_ready),
        .msg_data(msg_data), .crc_ok(crc_ok), .syndrome(syndrome),
        .err_clr(err_clr), .err_count(err_count)
    );

    crc3_checker #(.ERR_CNT_W(2)) dut_n (
        .clk(clk), .reset(reset), .en(en), .cw_valid(cw_valid), .cw_data(cw_data),
        .cw_ready(cw_ready_n), .out_valid(out_valid_n), .out_ready(out_ready),
        .msg_data(msg_data_n), .crc_ok(crc_ok_n), .syndrome(syndrome_n),
        .err_clr(err_clr), .err_count(err_count_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // CRC of the message followed by three zero bits, register held as a plain integer.
    function automatic int model_crc(input int msg);
        int c = 0;
        int b;
        for (int i = 0; i < 8; i++) begin
            b = (i < 5) ? ((msg >> (4 - i)) & 1) : 0;
            c = (c >> 1) | (((b ^ (c >> 2) ^ c) & 1) << 2);
        end
        return c;
    endfunction

    task automatic step(input bit entry);
        @(posedge clk);
        if (reset) begin
            exp_cnt8 = 0; exp_cnt2 = 0; exp_ov = 1'b0; exp_rdy = 1'b1;
        end else if (err_clr) begin
            exp_cnt8 = 0; exp_cnt2 = 0;
        end else if (entry && exp_bad) begin
            if (exp_cnt8 < 255) exp_cnt8++;
            if (exp_cnt2 < 3)   exp_cnt2++;
        end
        #1;
    endtask

    // Accept a codeword and shift it through; returns in DONE unless reset aborts it.
    task automatic shift_cw(input logic [7:0] cw, input int en_mode, input bit clr_entry,
                            input int rst_after, output bit aborted);
        int steps = 0;
        int cyc   = 0;
        bit entry;
        cw_valid = 1'b1; cw_data = cw; err_clr = 1'b0; reset = 1'b0; en = 1'($urandom % 2);
        exp_msg = cw[7:3];
        exp_syn = cw[2:0] ^ 3'(model_crc(int'(cw[7:3])));
        exp_bad = (exp_syn != 3'd0);
        step(1'b0);
        exp_rdy = 1'b0;
        aborted = 1'b0;
        while (steps < 8) begin
            cw_valid  = 1'($urandom % 2);
            cw_data   = 8'($urandom);
            out_ready = 1'($urandom % 2);
            if (cyc == rst_after) begin
                reset = 1'b1;
                step(1'b0);
                reset = 1'b0; cw_valid = 1'b0;
                aborted = 1'b1;
                return;
            end
            case (en_mode)
                0:       en = 1'b1;
                1:       en = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: en = (($urandom % 4) != 0) || (cyc > 100);
            endcase
            entry   = en && (steps == 7);
            err_clr = entry ? clr_entry : ((en_mode == 2) && (($urandom % 16) == 0));
            step(entry);
            err_clr = 1'b0;
            cyc++;
            if (en) steps++;
        end
        exp_ov = 1'b1;
    endtask

    task automatic finish_cw(input int stall);
        for (int k = 0; k < stall; k++) begin
            out_ready = 1'b0; cw_valid = 1'($urandom % 2); cw_data = 8'($urandom);
            step(1'b0);
        end
        out_ready = 1'b1;
        step(1'b0);
        exp_ov = 1'b0; exp_rdy = 1'b1;
        out_ready = 1'b0; cw_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("cw_ready", cw_ready, exp_rdy);
            chk("out_valid", out_valid, exp_ov);
            chk("cw_ready_w2", cw_ready_n, exp_rdy);
            chk("out_valid_w2", out_valid_n, exp_ov);
            chk("err_count", err_count, exp_cnt8);
            chk("err_count_w2", err_count_n, exp_cnt2);
            if (exp_ov) begin
                chk("msg_data", msg_data, exp_msg);
                chk("syndrome", syndrome, exp_syn);
                chk("crc_ok", crc_ok, (exp_syn == 3'd0));
                chk("msg_data_w2", msg_data_n, exp_msg);
                chk("syndrome_w2", syndrome_n, exp_syn);
                chk("crc_ok_w2", crc_ok_n, (exp_syn == 3'd0));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bit         ab;
        logic [7:0] cw;
        logic [4:0] m;
        int         sat_seq [5] = '{1, 2, 3, 3, 3};
        logic [7:0] bad_cw  [5] = '{8'hB2, 8'hB0, 8'hB1, 8'hB4, 8'hB5};

        reset = 1'b1; en = 1'b0; cw_valid = 1'b0; cw_data = 8'h00;
        out_ready = 1'b0; err_clr = 1'b0;
        exp_cnt8 = 0; exp_cnt2 = 0; exp_rdy = 1'b1; exp_ov = 1'b0; exp_bad = 1'b0;
        exp_msg = '0; exp_syn = '0;
        step(1'b0);
        step(1'b0);
        chk("rst_cw_ready", cw_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_msg_data", msg_data, 0);
        chk("rst_crc_ok", crc_ok, 0);
        chk("rst_syndrome", syndrome, 0);
        chk("rst_err_count", err_count, 0);
        reset = 1'b0;
        mon_en = 1'b1;

        chk("model_b3", model_crc(5'b10110), 3);
        chk("model_00", model_crc(0), 0);

        shift_cw(8'hB3, 0, 1'b0, -1, ab);
        chk("t1_msg", msg_data, 5'b10110);
        chk("t1_ok", crc_ok, 1);
        chk("t1_syn", syndrome, 0);
        chk("t1_cnt", err_count, 0);
        finish_cw(0);

        shift_cw(8'hB2, 0, 1'b0, -1, ab);
        chk("t2_ok", crc_ok, 0);
        chk("t2_syn", syndrome, 3'b001);
        chk("t2_cnt", err_count, 1);
        finish_cw(0);

        shift_cw(8'h00, 0, 1'b0, -1, ab);
        chk("t3_ok", crc_ok, 1);
        chk("t3_syn", syndrome, 0);
        finish_cw(5);
        chk("t3_ready_after", cw_ready, 1);

        shift_cw(8'hB3, 1, 1'b0, -1, ab);
        chk("t4_msg", msg_data, 5'b10110);
        chk("t4_ok", crc_ok, 1);
        finish_cw(1);

        shift_cw(8'hB3, 0, 1'b0, 3, ab);
        chk("t5_ready", cw_ready, 1);
        chk("t5_valid", out_valid, 0);
        chk("t5_cnt", err_count, 0);
        shift_cw(8'hB3, 0, 1'b0, -1, ab);
        chk("t5_ok", crc_ok, 1);
        finish_cw(0);

        for (int i = 0; i < 5; i++) begin
            shift_cw(bad_cw[i], 0, 1'b0, -1, ab);
            chk("t6_sat_w2", err_count_n, sat_seq[i]);
            finish_cw(0);
        end
        chk("t6_cnt8", err_count, 5);
        shift_cw(8'hB2, 0, 1'b1, -1, ab);
        chk("t6_clr_w2", err_count_n, 0);
        chk("t6_clr", err_count, 0);
        finish_cw(0);

        for (int i = 0; i < 60; i++) begin
            m  = 5'($urandom);
            cw = (($urandom % 2) == 0) ? {m, 3'(model_crc(int'(m)))} : 8'($urandom);
            shift_cw(cw, int'($urandom % 3), 1'(($urandom % 8) == 0),
                     (($urandom % 10) == 0) ? int'($urandom % 9) : -1, ab);
            if (!ab) finish_cw(int'($urandom % 4));
        end

        step(1'b0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
